// File: rtl/drink_dispense_pkg.sv
// Shared types for the coffee/soup vending controller: FSM states, product
// selection and coin encoding.
package drink_dispense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    DISPENSE,
    CHANGE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    COFFEE,
    SOUP
  } product_t;

  localparam int unsigned COIN_W       = 2;
  localparam logic [COIN_W-1:0] COIN_INVALID = 2'd0;

endpackage

// File: rtl/credit_accumulator.sv
// Credit register for the vending controller: ceiling-checked coin add,
// price subtraction, one-unit refund decrement and a registered reject pulse.
module credit_accumulator
  import drink_dispense_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned CREDIT_MAX = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_coin_insert,
  input  logic [COIN_W-1:0]   i_coin_value,
  input  logic                i_coin_open,
  input  logic                i_sub_en,
  input  logic [CREDIT_W-1:0] i_sub_amount,
  input  logic                i_dec_en,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_coin_accept,
  output logic                o_coin_reject
);

  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_coin_ok;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_reject;

  // Ceiling check uses one extra bit so an overflowing sum cannot wrap below the limit.
  assign w_sum     = {1'b0, r_credit} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, i_coin_value};
  assign w_coin_ok = i_coin_insert && i_coin_open && (i_coin_value != COIN_INVALID) &&
                     (w_sum <= (CREDIT_W + 1)'(CREDIT_MAX));

  always_comb begin
    w_credit_nxt = r_credit;
    if (w_coin_ok)
      w_credit_nxt = w_sum[CREDIT_W-1:0];
    if (i_sub_en)
      w_credit_nxt = w_credit_nxt - i_sub_amount;
    if (i_dec_en)
      w_credit_nxt = w_credit_nxt - CREDIT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_credit <= w_credit_nxt;
      r_reject <= i_coin_insert && !w_coin_ok;
    end
  end

  assign o_credit      = r_credit;
  assign o_coin_accept = w_coin_ok;
  assign o_coin_reject = r_reject;

endmodule

// File: rtl/drink_dispense_ctrl.sv
// Coffee/soup vending controller: credit accumulation, button arbitration,
// timed dispense and unit-by-unit change. Define DISPENSE_CTRL_CANCEL_EN for a cancel/refund button.
module drink_dispense_ctrl
  import drink_dispense_pkg::*;
#(
  parameter int unsigned CREDIT_W        = 6,
  parameter int unsigned COFFEE_PRICE    = 3,
  parameter int unsigned SOUP_PRICE      = 4,
  parameter int unsigned DISPENSE_CYCLES = 8,
  parameter int unsigned CREDIT_MAX      = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_insert,
  input  logic [1:0]          coin_value,
  input  logic                coffe_button,
  input  logic                soup_button,
`ifdef DISPENSE_CTRL_CANCEL_EN
  input  logic                cancel_button,
`endif
  output logic                coffee,
  output logic                soup,
  output logic                change_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(DISPENSE_CYCLES + 1);

  state_t              r_state, w_state_nxt;
  product_t            r_prod, w_prod_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CREDIT_W-1:0] w_credit;
  logic [CREDIT_W-1:0] w_sub_amount;
  logic                w_sub_en, w_dec_en, w_coin_open, w_coin_accept, w_cancel;
  logic                r_coffee, r_soup, r_change, r_busy;

`ifdef DISPENSE_CTRL_CANCEL_EN
  assign w_cancel = cancel_button;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_coin_open = (r_state == IDLE) || (r_state == CREDIT);

  credit_accumulator #(
    .CREDIT_W   (CREDIT_W),
    .CREDIT_MAX (CREDIT_MAX)
  ) u_credit (
    .i_clk         (clock),
    .i_rst         (reset),
    .i_coin_insert (coin_insert),
    .i_coin_value  (coin_value),
    .i_coin_open   (w_coin_open),
    .i_sub_en      (w_sub_en),
    .i_sub_amount  (w_sub_amount),
    .i_dec_en      (w_dec_en),
    .o_credit      (w_credit),
    .o_coin_accept (w_coin_accept),
    .o_coin_reject (coin_reject)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_prod_nxt   = r_prod;
    w_cnt_nxt    = r_cnt;
    w_sub_en     = 1'b0;
    w_sub_amount = '0;
    w_dec_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_coin_accept)
          w_state_nxt = CREDIT;
      end
      CREDIT: begin
        if (w_cancel) begin
          w_state_nxt = CHANGE;
        end else if (soup_button && (w_credit >= CREDIT_W'(SOUP_PRICE))) begin
          w_state_nxt  = DISPENSE;
          w_prod_nxt   = SOUP;
          w_sub_en     = 1'b1;
          w_sub_amount = CREDIT_W'(SOUP_PRICE);
          w_cnt_nxt    = CNT_W'(DISPENSE_CYCLES - 1);
        end else if (coffe_button && !soup_button && (w_credit >= CREDIT_W'(COFFEE_PRICE))) begin
          w_state_nxt  = DISPENSE;
          w_prod_nxt   = COFFEE;
          w_sub_en     = 1'b1;
          w_sub_amount = CREDIT_W'(COFFEE_PRICE);
          w_cnt_nxt    = CNT_W'(DISPENSE_CYCLES - 1);
        end
      end
      DISPENSE: begin
        if (r_cnt == '0)
          w_state_nxt = (w_credit != '0) ? CHANGE : IDLE;
        else
          w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      CHANGE: begin
        w_dec_en = (w_credit != '0);
        if (w_credit <= CREDIT_W'(1))
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_prod   <= NONE;
      r_cnt    <= '0;
      r_coffee <= 1'b0;
      r_soup   <= 1'b0;
      r_change <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prod   <= w_prod_nxt;
      r_cnt    <= w_cnt_nxt;
      r_coffee <= (w_state_nxt == DISPENSE) && (w_prod_nxt == COFFEE);
      r_soup   <= (w_state_nxt == DISPENSE) && (w_prod_nxt == SOUP);
      r_change <= (w_state_nxt == CHANGE);
      r_busy   <= (w_state_nxt == DISPENSE) || (w_state_nxt == CHANGE);
    end
  end

  assign coffee     = r_coffee;
  assign soup       = r_soup;
  assign change_out = r_change;
  assign credit     = w_credit;
  assign busy       = r_busy;

endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// Self-checking bench for drink_dispense_ctrl: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model of the vending rules.
module tb_drink_dispense_ctrl;

  localparam int P_COFFEE = 3;
  localparam int P_SOUP   = 4;
  localparam int N_DISP   = 8;
  localparam int C_MAX    = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       coin_insert;
  logic [1:0] coin_value;
  logic       coffe_button, soup_button, cancel_button;
  logic       coffee, soup, change_out, coin_reject, busy;
  logic [5:0] credit;

  int n_cmp = 0;
  int n_bad = 0;
  string g_tag = "reset";

  int m_credit, m_disp, m_prod;
  bit m_refund, m_reject;

  always #5 clock = ~clock;

  drink_dispense_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .coin_insert   (coin_insert),
    .coin_value    (coin_value),
    .coffe_button  (coffe_button),
    .soup_button   (soup_button),
`ifdef DISPENSE_CTRL_CANCEL_EN
    .cancel_button (cancel_button),
`endif
    .coffee        (coffee),
    .soup          (soup),
    .change_out    (change_out),
    .coin_reject   (coin_reject),
    .credit        (credit),
    .busy          (busy)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %0d expected %0d", g_tag, name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_disp = 0; m_prod = 0; m_refund = 0; m_reject = 0;
  endtask

  // One clock edge of the vending rules: a dispense timer, a refund phase, else accept coins/buttons.
  task automatic model_step(input bit ci, input int cv, input bit cb, input bit sb, input bit xb);
    int  c0;
    bit  ok;
    bit  cancel_eff;
    c0 = m_credit;
    m_reject = 0;
`ifdef DISPENSE_CTRL_CANCEL_EN
    cancel_eff = xb;
`else
    cancel_eff = 0;
`endif
    if (m_disp > 0) begin
      m_reject = ci;
      m_disp--;
      if (m_disp == 0 && m_credit > 0) m_refund = 1;
    end else if (m_refund) begin
      m_reject = ci;
      m_credit--;
      if (m_credit == 0) m_refund = 0;
    end else begin
      ok = ci && (cv != 0) && (c0 + cv <= C_MAX);
      m_reject = ci && !ok;
      if (ok) m_credit += cv;
      if (c0 > 0) begin
        if (cancel_eff) m_refund = 1;
        else if (sb && c0 >= P_SOUP) begin
          m_credit -= P_SOUP; m_disp = N_DISP; m_prod = 2;
        end else if (cb && !sb && c0 >= P_COFFEE) begin
          m_credit -= P_COFFEE; m_disp = N_DISP; m_prod = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    bit e_cof, e_soup;
    e_cof  = (m_disp > 0) && (m_prod == 1);
    e_soup = (m_disp > 0) && (m_prod == 2);
    chk("coffee", 32'(coffee), 32'(e_cof));
    chk("soup", 32'(soup), 32'(e_soup));
    chk("change_out", 32'(change_out), 32'(m_refund));
    chk("coin_reject", 32'(coin_reject), 32'(m_reject));
    chk("credit", 32'(credit), 32'(m_credit));
    chk("busy", 32'(busy), 32'(e_cof | e_soup | m_refund));
  endtask

  task automatic step(input bit ci, input bit [1:0] cv, input bit cb, input bit sb, input bit xb);
    coin_insert = ci; coin_value = cv; coffe_button = cb; soup_button = sb; cancel_button = xb;
    @(posedge clock);
    model_step(ci, int'(cv), cb, sb, xb);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 0, 0);
  endtask

  task automatic check_zero();
    chk("rst_coffee", 32'(coffee), 0);
    chk("rst_soup", 32'(soup), 0);
    chk("rst_change", 32'(change_out), 0);
    chk("rst_reject", 32'(coin_reject), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; coin_insert = 0; coin_value = 0;
    coffe_button = 0; soup_button = 0; cancel_button = 0;
    model_reset();
    #1;
    check_zero();
    @(posedge clock); #1;
    reset = 1'b0;

    g_tag = "coffee_exact";
    step(1, 2'd1, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(0, 2'd0, 1, 0, 0);
    idle(10);

    g_tag = "both_buttons";
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(0, 2'd0, 1, 1, 0);
    idle(12);

    g_tag = "soup_blocks";
    step(1, 2'd2, 0, 0, 0);
    step(1, 2'd1, 0, 0, 0);
    step(0, 2'd0, 0, 1, 0);
    step(0, 2'd0, 1, 1, 0);
    step(0, 2'd0, 1, 0, 0);
    idle(10);

    g_tag = "reject";
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd0, 0, 0, 0);
    step(1, 2'd1, 0, 1, 0);
    step(1, 2'd1, 0, 0, 0);
    idle(22);

    g_tag = "reset_in_change";
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    step(0, 2'd0, 1, 0, 0);
    for (int k = 0; k < 20 && !change_out; k++) idle(1);
    chk("pulse1", 32'(change_out), 1);
    idle(1);
    chk("pulse2", 32'(change_out), 1);
    reset = 1'b1;
    #1;
    model_reset();
    check_zero();
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);

`ifdef DISPENSE_CTRL_CANCEL_EN
    g_tag = "cancel";
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(0, 2'd0, 0, 1, 1);
    idle(8);
`endif

    g_tag = "random";
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 3) == 0, 2'($urandom), ($urandom % 4) == 0,
           ($urandom % 5) == 0, ($urandom % 12) == 0);
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
